// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide sequencer holding the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes, with the
// sign correction applied in a final FIX cycle.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       func_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] FnMult  = 6'b011000;
    localparam logic [5:0] FnMultu = 6'b011001;
    localparam logic [5:0] FnDiv   = 6'b011010;
    localparam logic [5:0] FnDivu  = 6'b011011;
    localparam logic [5:0] FnMthi  = 6'b010001;
    localparam logic [5:0] FnMtlo  = 6'b010011;

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDivZero} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    // Multiply: {partial product, multiplier}; divide: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [WIDTH-1:0]     opa_q, opa_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    // Operation decode and operand magnitudes.
    logic                 is_mul_op, is_div_op, is_signed_op;
    logic [WIDTH-1:0]     a_mag, b_mag;

    assign is_mul_op    = (func_code == FnMult) || (func_code == FnMultu);
    assign is_div_op    = (func_code == FnDiv) || (func_code == FnDivu);
    assign is_signed_op = (func_code == FnMult) || (func_code == FnDiv);
    assign a_mag        = (is_signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign b_mag        = (is_signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // One shift-add step: conditionally add multiplicand to the upper half, then shift right.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opa_q : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // One restoring-divide step: shift in the next dividend bit, trial-subtract the divisor.
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       rem_diff;
    logic [2*WIDTH-1:0]   div_next;

    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign rem_diff = rem_sh - {1'b0, opa_q};
    assign div_next = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    // Sign-corrected results written in FIX.
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    assign prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    assign quo_fix  = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    assign rem_fix  = rem_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        if (flush) begin
            // Abandon whatever is in flight; a same-cycle start is dropped too.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (is_mul_op || is_div_op) begin
                            dz_d      = 1'b0;
                            busy_d    = 1'b1;
                            is_div_d  = is_div_op;
                            neg_d     = is_signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                            rem_neg_d = is_signed_op & a[WIDTH-1];
                            if (is_div_op) begin
                                opa_d = b_mag;
                                acc_d = {{WIDTH{1'b0}}, a_mag};
                            end else begin
                                opa_d = a_mag;
                                acc_d = {{WIDTH{1'b0}}, b_mag};
                            end
                            if (is_div_op && (b == '0)) begin
                                state_d = StDivZero;
                            end else begin
                                state_d = StCalc;
                                cnt_d   = CntW'(WIDTH - 1);
                            end
                        end else if (func_code == FnMthi) begin
                            hi_d = a;
                        end else if (func_code == FnMtlo) begin
                            lo_d = a;
                        end
                    end
                end
                StCalc: begin
                    busy_d = 1'b1;
                    acc_d  = is_div_q ? div_next : mul_next;
                    if (cnt_q == '0) begin
                        state_d = StFix;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StFix: begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
                StDivZero: begin
                    done_d  = 1'b1;
                    dz_d    = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            acc_q     <= '0;
            opa_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO/div_by_zero are queued when an
// operation is issued and compared whenever the DUT pulses done.
module tb_muldiv_unit;

    localparam logic [5:0] FnMult  = 6'b011000;
    localparam logic [5:0] FnMultu = 6'b011001;
    localparam logic [5:0] FnDiv   = 6'b011010;
    localparam logic [5:0] FnDivu  = 6'b011011;
    localparam logic [5:0] FnMthi  = 6'b010001;
    localparam logic [5:0] FnMtlo  = 6'b010011;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  func_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    int checks;
    int passes;

    // Reference copies of HI/LO as the bench expects them.
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .func_code   (func_code),
        .a           (op_a),
        .b           (op_b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: every done pulse pops one expected result.
    always @(posedge clk) begin
        #1;
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL sb_unexpected_done: got done=1 with no pending op, required done=0");
            end else begin
                mon_e = sb_q.pop_front();
                checks++;
                if (hi !== mon_e.hi)
                    $display("FAIL sb_hi: got %08h required %08h", hi, mon_e.hi);
                else passes++;
                checks++;
                if (lo !== mon_e.lo)
                    $display("FAIL sb_lo: got %08h required %08h", lo, mon_e.lo);
                else passes++;
                checks++;
                if (div_by_zero !== mon_e.dz)
                    $display("FAIL sb_dz: got %0b required %0b", div_by_zero, mon_e.dz);
                else passes++;
            end
        end
    end

    // Present an operation on the inputs and queue its expected result.
    task automatic drive_op(input logic [5:0] f, input logic [31:0] va, input logic [31:0] vb,
                            input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
        exp_t e;
        start     = 1'b1;
        func_code = f;
        op_a      = va;
        op_b      = vb;
        e.hi = ehi;
        e.lo = elo;
        e.dz = edz;
        sb_q.push_back(e);
    endtask

    // Step edges until done, counting edges and busy samples; bounded.
    task automatic wait_done(output int edges, output int busy_n, output bit ok);
        edges  = 0;
        busy_n = 0;
        ok     = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            edges++;
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (busy === 1'b1) busy_n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #7;
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000)
            $display("FAIL reset_flags: got %03b required 000", {busy, done, div_by_zero});
        else passes++;
        checks++;
        if ({hi, lo} !== 64'h0)
            $display("FAIL reset_hilo: got %016h required 0", {hi, lo});
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000)
            $display("FAIL idle_flags: got %03b required 000", {busy, done, div_by_zero});
        else passes++;
        m_hi = 32'h0;
        m_lo = 32'h0;
    endtask

    task automatic test_mult_signed();
        int edges, busy_n;
        bit ok;
        drive_op(FnMult, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        wait_done(edges, busy_n, ok);
        checks++;
        if (!ok) $display("FAIL mult_timeout: got no done, required done within 100 edges");
        else passes++;
        checks++;
        if (edges - 1 != 33) $display("FAIL mult_latency: got %0d required 33", edges - 1);
        else passes++;
        checks++;
        if (busy_n != 33) $display("FAIL mult_busy_cycles: got %0d required 33", busy_n);
        else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL mult_busy_at_done: got %0b required 0", busy);
        else passes++;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) $display("FAIL mult_done_pulse: got %0b required 0", done);
        else passes++;
        m_hi = 32'hFFFF_FFFF;
        m_lo = 32'hFFFF_FFEB;
    endtask

    task automatic test_back_to_back();
        int edges, busy_n;
        bit ok;
        drive_op(FnMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        wait_done(edges, busy_n, ok);
        checks++;
        if (!ok || edges - 1 != 33)
            $display("FAIL multu_latency: got ok=%0b edges=%0d required ok=1 edges=33", ok, edges - 1);
        else passes++;
        // Issue in the done cycle.
        drive_op(FnDivu, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        wait_done(edges, busy_n, ok);
        checks++;
        if (!ok || edges != 34)
            $display("FAIL b2b_latency: got ok=%0b edges=%0d required ok=1 edges=34", ok, edges);
        else passes++;
        checks++;
        if (busy_n != 33) $display("FAIL b2b_busy_cycles: got %0d required 33", busy_n);
        else passes++;
        m_hi = 32'd2;
        m_lo = 32'd14;
    endtask

    task automatic test_div_signed();
        int edges, busy_n;
        bit ok;
        drive_op(FnDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        wait_done(edges, busy_n, ok);
        checks++;
        if (!ok || edges - 1 != 33)
            $display("FAIL div_latency: got ok=%0b edges=%0d required ok=1 edges=33", ok, edges - 1);
        else passes++;
        drive_op(FnDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        wait_done(edges, busy_n, ok);
        checks++;
        if (!ok || edges - 1 != 33)
            $display("FAIL divovf_latency: got ok=%0b edges=%0d required ok=1 edges=33", ok, edges - 1);
        else passes++;
        m_hi = 32'h0;
        m_lo = 32'h8000_0000;
    endtask

    task automatic test_div_zero();
        int edges, busy_n;
        bit ok;
        logic [5:0] others [4];
        others[0] = 6'b100000;
        others[1] = 6'b010000;
        others[2] = 6'b011100;
        others[3] = 6'b000000;
        start = 1'b1; func_code = FnMthi; op_a = 32'h1234; op_b = 32'h0;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (hi !== 32'h1234) $display("FAIL mthi_hi: got %08h required 00001234", hi);
        else passes++;
        checks++;
        if ({busy, done} !== 2'b00) $display("FAIL mthi_flags: got %02b required 00", {busy, done});
        else passes++;
        start = 1'b1; func_code = FnMtlo; op_a = 32'h5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (lo !== 32'h5678 || hi !== 32'h1234)
            $display("FAIL mtlo_hilo: got %08h/%08h required 00001234/00005678", hi, lo);
        else passes++;
        m_hi = 32'h1234;
        m_lo = 32'h5678;
        drive_op(FnDivu, 32'd7, 32'd0, m_hi, m_lo, 1'b1);
        wait_done(edges, busy_n, ok);
        checks++;
        if (!ok || edges != 2)
            $display("FAIL dz_latency: got ok=%0b edges=%0d required ok=1 edges=2", ok, edges);
        else passes++;
        checks++;
        if (busy_n != 1) $display("FAIL dz_busy_cycles: got %0d required 1", busy_n);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            start = 1'b1; func_code = others[i]; op_a = 32'hDEAD_BEEF; op_b = 32'h0;
            @(posedge clk);
            #1;
            start = 1'b0;
            checks++;
            if ({hi, lo, div_by_zero, busy, done} !== {m_hi, m_lo, 1'b1, 1'b0, 1'b0})
                $display("FAIL ignored_fn_%0d: got %08h/%08h dz=%0b busy=%0b done=%0b required %08h/%08h dz=1 busy=0 done=0",
                         i, hi, lo, div_by_zero, busy, done, m_hi, m_lo);
            else passes++;
        end
    endtask

    task automatic test_flush();
        int done_seen;
        start = 1'b1; func_code = FnMult; op_a = 32'd5; op_b = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if ({busy, div_by_zero} !== 2'b10)
            $display("FAIL flush_accept: got busy/dz=%02b required 10", {busy, div_by_zero});
        else passes++;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if ({busy, done} !== 2'b00) $display("FAIL flush_flags: got %02b required 00", {busy, done});
        else passes++;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) $display("FAIL flush_no_done: got %0d pulses required 0", done_seen);
        else passes++;
        checks++;
        if (hi !== m_hi || lo !== m_lo)
            $display("FAIL flush_hilo: got %08h/%08h required %08h/%08h", hi, lo, m_hi, m_lo);
        else passes++;
        start = 1'b1; flush = 1'b1; func_code = FnMult;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        checks++;
        if (busy !== 1'b0) $display("FAIL flush_start_same: got busy=%0b required 0", busy);
        else passes++;
    endtask

    task automatic test_async_reset();
        int edges, busy_n;
        bit ok;
        start = 1'b1; func_code = FnMult; op_a = 32'd5; op_b = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, div_by_zero} !== 3'b000)
            $display("FAIL arst_flags: got %03b required 000", {busy, done, div_by_zero});
        else passes++;
        checks++;
        if ({hi, lo} !== 64'h0) $display("FAIL arst_hilo: got %016h required 0", {hi, lo});
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        drive_op(FnMult, 32'd5, 32'd5, 32'h0, 32'd25, 1'b0);
        wait_done(edges, busy_n, ok);
        checks++;
        if (!ok || edges - 1 != 33)
            $display("FAIL post_rst_latency: got ok=%0b edges=%0d required ok=1 edges=33", ok, edges - 1);
        else passes++;
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        flush     = 1'b0;
        func_code = 6'b0;
        op_a      = 32'h0;
        op_b      = 32'h0;
        test_reset();
        test_mult_signed();
        test_back_to_back();
        test_div_signed();
        test_div_zero();
        test_flush();
        test_async_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) $display("FAIL sb_drain: got %0d pending required 0", sb_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
